// File: rtl/mmio_uart.sv
// ============================================================================
// Module   : mmio_uart
// Brief    : MMIO UART with TX/RX byte FIFOs, STATUS register, sticky errors.
//            Define MMIO_UART_PARITY_EN for 8E1 framing (default is 8N1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module mmio_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_TW = $clog2(CLKS_PER_BIT);
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(CLKS_PER_BIT - 1);
    localparam logic [c_TW-1:0] c_TICK_HALF = c_TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_PW:0]   c_FULL      = (c_PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef MMIO_UART_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    logic w_sel_data, w_sel_stat;
    assign w_sel_data = (addr[3:2] == 2'd0);
    assign w_sel_stat = (addr[3:2] == 2'd1);

    logic w_unused;
    assign w_unused = ^{addr[31:4], addr[1:0], wdata[31:9]};

    // ---------------- TX FIFO ----------------
    logic [7:0]      r_tx_mem [FIFO_DEPTH];
    logic [c_PW-1:0] r_tx_wp, r_tx_rp;
    logic [c_PW:0]   r_tx_cnt;
    logic w_tx_full, w_tx_empty, w_tx_wr, w_tx_push, w_tx_pop;

    assign w_tx_full  = (r_tx_cnt == c_FULL);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_wr    = we && w_sel_data;
    assign w_tx_push  = w_tx_wr && (!w_tx_full || w_tx_pop);

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
            if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
            else if (w_tx_pop && !w_tx_push) r_tx_cnt <= r_tx_cnt - 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    state_t          r_tx_state, w_tx_next;
    logic [c_TW-1:0] r_tx_tick;
    logic [2:0]      r_tx_bit;
    logic [7:0]      r_tx_shift;
    logic            w_tx_bit_end, w_tx_line;
`ifdef MMIO_UART_PARITY_EN
    logic            r_tx_par;
`endif

    assign w_tx_bit_end = (r_tx_tick == c_TICK_LAST);
    assign uart_tx      = w_tx_line;

    // Reloading from STOP keeps back-to-back frames gap-free.
    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_pop  = 1'b0;
        w_tx_line = 1'b1;
        case (r_tx_state)
            S_IDLE: begin
                if (!w_tx_empty) begin
                    w_tx_pop  = 1'b1;
                    w_tx_next = S_START;
                end
            end
            S_START: begin
                w_tx_line = 1'b0;
                if (w_tx_bit_end) w_tx_next = S_DATA;
            end
            S_DATA: begin
                w_tx_line = r_tx_shift[0];
`ifdef MMIO_UART_PARITY_EN
                if (w_tx_bit_end && r_tx_bit == 3'd7) w_tx_next = S_PARITY;
            end
            S_PARITY: begin
                w_tx_line = r_tx_par;
                if (w_tx_bit_end) w_tx_next = S_STOP;
`else
                if (w_tx_bit_end && r_tx_bit == 3'd7) w_tx_next = S_STOP;
`endif
            end
            S_STOP: begin
                if (w_tx_bit_end) begin
                    if (!w_tx_empty) begin
                        w_tx_pop  = 1'b1;
                        w_tx_next = S_START;
                    end else begin
                        w_tx_next = S_IDLE;
                    end
                end
            end
            default: w_tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= S_IDLE;
            r_tx_tick  <= '0;
            r_tx_bit   <= 3'd1;
            r_tx_shift <= '0;
`ifdef MMIO_UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            r_tx_state <= w_tx_next;
            if (w_tx_pop) begin
                r_tx_shift <= r_tx_mem[r_tx_rp];
`ifdef MMIO_UART_PARITY_EN
                r_tx_par   <= ^r_tx_mem[r_tx_rp];
`endif
                r_tx_tick  <= '0;
            end else if (r_tx_state != S_IDLE) begin
                if (w_tx_bit_end) begin
                    r_tx_tick <= '0;
                    if (r_tx_state == S_START) r_tx_bit <= 3'd0;
                    if (r_tx_state == S_DATA) begin
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bit   <= r_tx_bit + 1'b1;
                    end
                end else begin
                    r_tx_tick <= r_tx_tick + 1'b1;
                end
            end
        end
    end

    // ---------------- RX synchroniser ----------------
    logic r_rx_s1, r_rx_s2, r_rx_prev;
    always_ff @(posedge clk) begin
        if (rst) begin
            {r_rx_s1, r_rx_s2, r_rx_prev} <= 3'b111;
        end else begin
            r_rx_s1   <= uart_rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]      r_rx_mem [FIFO_DEPTH];
    logic [c_PW-1:0] r_rx_wp, r_rx_rp;
    logic [c_PW:0]   r_rx_cnt;
    logic [7:0]      r_rx_shift;
    logic w_rx_full, w_rx_empty, w_rx_push, w_rx_pop, w_rx_deliver;

    assign w_rx_full  = (r_rx_cnt == c_FULL);
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_pop   = re && w_sel_data && !w_rx_empty;
    assign w_rx_push  = w_rx_deliver && (!w_rx_full || w_rx_pop);

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
            else if (w_rx_pop && !w_rx_push) r_rx_cnt <= r_rx_cnt - 1'b1;
        end
    end

    // ---------------- RX FSM ----------------
    state_t          r_rx_state, w_rx_next;
    logic [c_TW-1:0] r_rx_tick;
    logic [2:0]      r_rx_bit;
    logic            w_rx_sample, w_rx_stop_evt, w_rx_ferr_set;
`ifdef MMIO_UART_PARITY_EN
    logic            r_rx_par_bad;
`endif

    // Start bit is checked at mid-bit; later samples fall a full bit apart.
    assign w_rx_sample = (r_rx_state == S_START) ? (r_rx_tick == c_TICK_HALF)
                                                 : (r_rx_tick == c_TICK_LAST);

    always_comb begin
        w_rx_next     = r_rx_state;
        w_rx_stop_evt = 1'b0;
        case (r_rx_state)
            S_IDLE:  if (r_rx_prev && !r_rx_s2) w_rx_next = S_START;
            S_START: if (w_rx_sample) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
`ifdef MMIO_UART_PARITY_EN
            S_DATA:   if (w_rx_sample && r_rx_bit == 3'd7) w_rx_next = S_PARITY;
            S_PARITY: if (w_rx_sample) w_rx_next = S_STOP;
`else
            S_DATA:   if (w_rx_sample && r_rx_bit == 3'd7) w_rx_next = S_STOP;
`endif
            S_STOP: begin
                if (w_rx_sample) begin
                    w_rx_stop_evt = 1'b1;
                    w_rx_next     = S_IDLE;
                end
            end
            default: w_rx_next = S_IDLE;
        endcase
    end

    assign w_rx_ferr_set = w_rx_stop_evt && !r_rx_s2;
`ifdef MMIO_UART_PARITY_EN
    assign w_rx_deliver  = w_rx_stop_evt && r_rx_s2 && !r_rx_par_bad;
`else
    assign w_rx_deliver  = w_rx_stop_evt && r_rx_s2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state   <= S_IDLE;
            r_rx_tick    <= '0;
            r_rx_bit     <= 3'd1;
            r_rx_shift   <= '0;
`ifdef MMIO_UART_PARITY_EN
            r_rx_par_bad <= 1'b0;
`endif
        end else begin
            r_rx_state <= w_rx_next;
            if (r_rx_state == S_IDLE) begin
                r_rx_tick <= '0;
            end else if (w_rx_sample) begin
                r_rx_tick <= '0;
                if (r_rx_state == S_START) r_rx_bit <= 3'd0;
                if (r_rx_state == S_DATA) begin
                    r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                    r_rx_bit   <= r_rx_bit + 1'b1;
                end
`ifdef MMIO_UART_PARITY_EN
                if (r_rx_state == S_PARITY) r_rx_par_bad <= (^r_rx_shift) ^ r_rx_s2;
`endif
            end else begin
                r_rx_tick <= r_rx_tick + 1'b1;
            end
        end
    end

    // ---------------- Sticky status (set wins over clear) ----------------
    logic r_rx_ovr, r_ferr, r_tx_ovf, w_clr, w_perr_bit;
    assign w_clr = we && w_sel_stat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_ovr <= 1'b0;
            r_ferr   <= 1'b0;
            r_tx_ovf <= 1'b0;
        end else begin
            r_rx_ovr <= (w_rx_deliver && w_rx_full && !w_rx_pop) | (r_rx_ovr & ~(w_clr & wdata[4]));
            r_ferr   <= w_rx_ferr_set | (r_ferr & ~(w_clr & wdata[5]));
            r_tx_ovf <= (w_tx_wr && w_tx_full && !w_tx_pop) | (r_tx_ovf & ~(w_clr & wdata[8]));
        end
    end

`ifdef MMIO_UART_PARITY_EN
    logic r_perr;
    always_ff @(posedge clk) begin
        if (rst) r_perr <= 1'b0;
        else     r_perr <= (w_rx_stop_evt && r_rx_par_bad) | (r_perr & ~(w_clr & wdata[7]));
    end
    assign w_perr_bit = r_perr;
`else
    assign w_perr_bit = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (addr[3:2])
            2'd0: if (!w_rx_empty) rdata = {24'b0, r_rx_mem[r_rx_rp]};
            2'd1: rdata = {23'b0, r_tx_ovf, w_perr_bit, (r_tx_state != S_IDLE), r_ferr,
                           r_rx_ovr, w_rx_full, !w_rx_empty, w_tx_empty, w_tx_full};
            default: rdata = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart.sv
// ============================================================================
// Module   : tb_mmio_uart
// Brief    : Directed/randomised bench for mmio_uart (CLKS_PER_BIT=4, depth 4).
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mmio_uart;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef MMIO_UART_PARITY_EN
    localparam int NB     = 11;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int NB     = 10;
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0, wdata = '0;
    logic        we = 1'b0, re = 1'b0;
    logic [31:0] rdata;
    logic        uart_tx, uart_rx;
    logic        tb_rx = 1'b1, loopback = 1'b0;

    int errors = 0, checks = 0, cyc = 0;

    logic [7:0] mon_q[$];
    int         mon_t[$];
    logic       mon_ok[$];
    logic       mon_par[$];

    assign uart_rx = loopback ? uart_tx : tb_rx;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mmio_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .uart_rx(uart_rx), .uart_tx(uart_tx)
    );

    // Serial line image of one byte: index 0 is the start bit.
    function automatic logic [NB-1:0] frame_vec(input logic [7:0] b);
        logic [NB-1:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i+1] = b[i];
        if (PAR_EN) v[NB-2] = ^b;
        v[NB-1] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(posedge clk); #1;
        we = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic pop, output logic [31:0] d);
        addr = a; re = pop;
        #1 d = rdata;
        if (pop) begin @(posedge clk); #1; re = 1'b0; end
        addr = '0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic bad_par);
        logic [NB-1:0] v;
        v = frame_vec(b);
        v[NB-1] = stop;
        v[NB-2] = v[NB-2] ^ (bad_par & PAR_EN);
        for (int k = 0; k < NB; k++) begin
            tb_rx = v[k];
            step(CPB);
        end
        tb_rx = 1'b1;
        step(2 * CPB);
    endtask

    task automatic mon_clear();
        mon_q.delete(); mon_t.delete(); mon_ok.delete(); mon_par.delete();
    endtask

    // Line decoder: samples each bit near its centre and logs complete frames.
    initial begin : monitor
        logic ok, abort, p;
        logic [7:0] b;
        int t;
        forever begin
            @(posedge clk); #1;
            if (!rst && uart_tx === 1'b0) begin
                t = cyc; ok = 1'b1; abort = 1'b0; b = '0; p = 1'b0;
                repeat (CPB / 2) begin @(posedge clk); #1; if (rst) abort = 1'b1; end
                if (uart_tx !== 1'b0) ok = 1'b0;
                for (int k = 1; k < NB; k++) begin
                    repeat (CPB) begin @(posedge clk); #1; if (rst) abort = 1'b1; end
                    if (k <= 8)          b[k-1] = uart_tx;
                    else if (k == NB-1)  begin if (uart_tx !== 1'b1) ok = 1'b0; end
                    else                 p = uart_tx;
                end
                repeat (CPB - CPB / 2 - 1) begin @(posedge clk); #1; if (rst) abort = 1'b1; end
                if (!abort) begin
                    mon_q.push_back(b); mon_t.push_back(t);
                    mon_ok.push_back(ok); mon_par.push_back(p);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0]   r;
        logic [7:0]    bytes[$];
        logic [7:0]    b;
        logic [NB-1:0] v;
        int            budget;
        logic          quiet;

        // Reset state
        rst = 1'b1;
        step(3);
        check("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
        bus_read(32'h4, 1'b0, r);  check("rst_status", r, 32'h002);
        step(1);
        rst = 1'b0;
        step(2);
        bus_read(32'h0, 1'b0, r);  check("empty_data", r, 32'h0);
        bus_write(32'h8, 32'hFFFF_FFFF);
        bus_read(32'h8, 1'b0, r);  check("rsvd_8", r, 32'h0);
        bus_read(32'hC, 1'b0, r);  check("rsvd_c", r, 32'h0);
        bus_read(32'h4, 1'b0, r);  check("rsvd_write_ignored", r, 32'h002);

        // Exact TX waveform of 0x55
        step(1);
        bus_write(32'h0, 32'h55);
        step(1);
        v = frame_vec(8'h55);
        for (int k = 0; k < NB; k++) begin
            for (int j = 0; j < CPB; j++) begin
                check($sformatf("tx55_bit%0d_s%0d", k, j), {31'b0, uart_tx}, {31'b0, v[k]});
                step(1);
            end
        end
        bus_read(32'h4, 1'b0, r);  check("tx55_idle_status", r, 32'h002);

        // Random back-to-back TX bytes
        step(5);
        mon_clear(); bytes.delete();
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            bytes.push_back(b);
            bus_write(32'h0, {24'b0, b});
        end
        budget = 0;
        while (mon_q.size() < 3 && budget < 500) begin step(1); budget++; end
        check("txr_count", 32'(mon_q.size()), 32'd3);
        for (int i = 0; i < mon_q.size() && i < 3; i++) begin
            check($sformatf("txr_byte%0d", i), {24'b0, mon_q[i]}, {24'b0, bytes[i]});
            check($sformatf("txr_frame%0d", i), {31'b0, mon_ok[i]}, 32'h1);
            if (PAR_EN) check($sformatf("txr_par%0d", i), {31'b0, mon_par[i]}, {31'b0, ^bytes[i]});
            if (i > 0) check($sformatf("txr_gap%0d", i), 32'(mon_t[i] - mon_t[i-1]), 32'(NB * CPB));
        end

        // Loopback
        step(20);
        loopback = 1'b1;
        bus_write(32'h0, 32'hA3);
        budget = 0; r = '0;
        while (r[2] !== 1'b1 && budget < 300) begin bus_read(32'h4, 1'b0, r); step(1); budget++; end
        check("lb_rx_valid", {31'b0, r[2]}, 32'h1);
        bus_read(32'h0, 1'b1, r);  check("lb_data", r, 32'h0000_00A3);
        bus_read(32'h4, 1'b0, r);  check("lb_after_pop", r, 32'h002);
        bytes.delete();
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            bytes.push_back(b);
            bus_write(32'h0, {24'b0, b});
        end
        step(2 * NB * CPB + 40);
        for (int i = 0; i < 2; i++) begin
            bus_read(32'h0, 1'b1, r);
            check($sformatf("lb_rand%0d", i), r, {24'b0, bytes[i]});
        end
        bus_read(32'h4, 1'b0, r);  check("lb_drained", r, 32'h002);
        loopback = 1'b0;
        step(5);

        // TX overflow: six quick writes, five frames on the wire
        mon_clear(); bytes.delete();
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            bytes.push_back(b);
            bus_write(32'h0, {24'b0, b});
        end
        bus_read(32'h4, 1'b0, r);  check("txovf_status", r, 32'h141);
        budget = 0;
        while (mon_q.size() < 5 && budget < 1000) begin step(1); budget++; end
        step(2 * NB * CPB);
        check("txovf_frames", 32'(mon_q.size()), 32'd5);
        for (int i = 0; i < mon_q.size() && i < 5; i++) begin
            check($sformatf("txovf_byte%0d", i), {24'b0, mon_q[i]}, {24'b0, bytes[i]});
            if (i > 0) check($sformatf("txovf_gap%0d", i), 32'(mon_t[i] - mon_t[i-1]), 32'(NB * CPB));
        end
        bus_read(32'h4, 1'b0, r);  check("txovf_sticky", r, 32'h102);
        bus_write(32'h4, 32'h100);
        bus_read(32'h4, 1'b0, r);  check("txovf_cleared", r, 32'h002);

        // RX overrun: five frames into a four-entry FIFO
        bytes.delete();
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            bytes.push_back(b);
            send_frame(b, 1'b1, 1'b0);
        end
        bus_read(32'h4, 1'b0, r);  check("rxovr_status", r, 32'h01E);
        for (int i = 0; i < 4; i++) begin
            bus_read(32'h0, 1'b1, r);
            check($sformatf("rxovr_byte%0d", i), r, {24'b0, bytes[i]});
        end
        bus_read(32'h4, 1'b0, r);  check("rxovr_drained", r, 32'h012);
        bus_write(32'h4, 32'h10);
        bus_read(32'h4, 1'b0, r);  check("rxovr_cleared", r, 32'h002);

        // Framing error
        send_frame(8'($urandom), 1'b0, 1'b0);
        bus_read(32'h4, 1'b0, r);  check("ferr_status", r, 32'h022);
        bus_write(32'h4, 32'h20);
        bus_read(32'h4, 1'b0, r);  check("ferr_cleared", r, 32'h002);

        // One-cycle glitch is rejected; a following good frame is received
        tb_rx = 1'b0;
        step(1);
        tb_rx = 1'b1;
        step(30);
        bus_read(32'h4, 1'b0, r);  check("glitch_status", r, 32'h002);
        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b0);
        bus_read(32'h4, 1'b0, r);  check("post_glitch_status", r, 32'h006);
        bus_read(32'h0, 1'b1, r);  check("post_glitch_byte", r, {24'b0, b});

`ifdef MMIO_UART_PARITY_EN
        // Parity generation and checking
        step(5);
        mon_clear();
        bus_write(32'h0, 32'h07);
        budget = 0;
        while (mon_q.size() < 1 && budget < 300) begin step(1); budget++; end
        check("par_tx_count", 32'(mon_q.size()), 32'd1);
        if (mon_q.size() > 0) begin
            check("par_tx_byte", {24'b0, mon_q[0]}, 32'h07);
            check("par_tx_bit", {31'b0, mon_par[0]}, 32'h1);
        end
        send_frame(8'h5A, 1'b1, 1'b1);
        bus_read(32'h4, 1'b0, r);  check("par_rx_status", r, 32'h082);
        bus_write(32'h4, 32'h80);
        bus_read(32'h4, 1'b0, r);  check("par_cleared", r, 32'h002);
`endif

        // Reset during data bit 3 with a second byte still queued
        step(10);
        mon_clear();
        bus_write(32'h0, {24'b0, 8'($urandom)});
        bus_write(32'h0, {24'b0, 8'($urandom)});
        step(4 * CPB + 1);
        rst = 1'b1;
        step(1);
        check("rst_mid_uart_tx", {31'b0, uart_tx}, 32'h1);
        bus_read(32'h4, 1'b0, r);  check("rst_mid_status", r, 32'h002);
        step(1);
        rst = 1'b0;
        quiet = 1'b1;
        repeat (3 * NB * CPB) begin
            step(1);
            if (uart_tx !== 1'b1) quiet = 1'b0;
        end
        check("rst_mid_quiet", {31'b0, quiet}, 32'h1);
        check("rst_mid_frames", 32'(mon_q.size()), 32'd0);
        bus_read(32'h4, 1'b0, r);  check("rst_mid_final", r, 32'h002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
